// File: rtl/irq_unit_pkg.sv
//------------------------------------------------------------------------------
// irq_unit_pkg : shared constants and types for the interrupt controller
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package irq_unit_pkg;

    localparam int SREG_IRQ_PC    = 'h3;
    localparam int SREG_IRQ_CAUSE = 'h5;
    localparam int SREG_IRQ_MASK  = 'hC;
    localparam int SREG_IRQ_PEND  = 'hD;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } irq_state_e;

    // synchronous cause codes sit just above the external line numbers
    localparam int CAUSE_SYS_OFS  = 0;
    localparam int CAUSE_TRAP_OFS = 1;
    localparam int CAUSE_MEM_OFS  = 2;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
//------------------------------------------------------------------------------
// irq_prio_enc : fixed-priority encoder, lowest set index wins
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_prio_enc #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic [N-1:0]  req_i,
    output logic          hit_o,
    output logic [CW-1:0] code_o
);

    always_comb begin
        hit_o  = |req_i;
        code_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) code_o = CW'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_unit.sv
//------------------------------------------------------------------------------
// irq_unit : interrupt/exception arbiter, cause/resume-PC capture, handler FSM
// Build option: IRQ_VECTORED_EN selects vectored handler targets
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_unit
    import irq_unit_pkg::*;
#(
    parameter int              RW         = 16,
    parameter int              NSRC       = 8,
    parameter logic [NSRC-1:0] EDGE_MASK  = '0,
    parameter int              INT_VEC    = 1,
    parameter int              VEC_STRIDE = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_exec_submit,
    input  logic [RW-1:0]   i_exec_pc,
    input  logic            i_sys,
    input  logic            i_trap_flag,
    input  logic            i_mem_exception,
    input  logic            i_irt,
    input  logic            i_irq_en,
    input  logic [NSRC-1:0] i_irq,
    input  logic [RW-1:0]   i_sreg_addr,
    input  logic            i_sreg_we,
    input  logic [RW-1:0]   i_sreg_data,
    output logic [RW-1:0]   o_sreg_data,
    output logic            o_irq,
    output logic            o_flush,
    output logic [RW-1:0]   o_target_pc,
    output logic [RW-1:0]   o_irq_pc,
    output logic            o_in_handler
);

    localparam int            CW     = $clog2(NSRC + 3);
    localparam logic [CW-1:0] C_SYS  = CW'(NSRC + CAUSE_SYS_OFS);
    localparam logic [CW-1:0] C_TRAP = CW'(NSRC + CAUSE_TRAP_OFS);
    localparam logic [CW-1:0] C_MEM  = CW'(NSRC + CAUSE_MEM_OFS);

    generate
        if (NSRC < 1 || NSRC > 16 || VEC_STRIDE < 0) begin : g_param_err
            $error("irq_unit: NSRC must be 1..16 and VEC_STRIDE non-negative");
        end
    endgenerate

    irq_state_e      state_q, state_d;
    logic [NSRC-1:0] mask_q, pend_edge_q, pend_edge_d, irq_prev_q;
    logic            prev_sys_q, prev_trap_q, flush_q, cause_vld_q;
    logic [CW-1:0]   cause_code_q;
    logic [RW-1:0]   mem_pc_q, irq_pc_q;

    logic [NSRC-1:0] w_pend, w_ext, w_edge_set, w_w1c, w_take_clr;
    logic            w_ext_hit, w_irq, w_take_ext, w_sreg_wr;
    logic [CW-1:0]   w_ext_code, w_code;
    logic [RW-1:0]   w_cause_rd;

    // level lines are live; only edge lines hold state
    assign w_pend     = (i_irq & ~EDGE_MASK) | (pend_edge_q & EDGE_MASK);
    assign w_ext      = w_pend & mask_q & {NSRC{i_irq_en & (state_q == ST_RUN)}};
    assign w_edge_set = i_irq & ~irq_prev_q & EDGE_MASK;

    irq_prio_enc #(
        .N  (NSRC),
        .CW (CW)
    ) u_prio_enc (
        .req_i  (w_ext),
        .hit_o  (w_ext_hit),
        .code_o (w_ext_code)
    );

    always_comb begin
        w_code = w_ext_code;
        if (i_mem_exception)  w_code = C_MEM;
        else if (prev_trap_q) w_code = C_TRAP;
        else if (prev_sys_q)  w_code = C_SYS;
    end

    assign w_irq      = i_mem_exception | prev_trap_q | prev_sys_q | w_ext_hit;
    assign w_take_ext = w_irq & ~i_mem_exception & ~prev_trap_q & ~prev_sys_q;
    assign w_sreg_wr  = i_sreg_we & i_exec_submit & ~w_irq;
    assign w_take_clr = w_take_ext ? ((NSRC'(1) << w_ext_code) & EDGE_MASK) : '0;
    assign w_w1c      = (w_sreg_wr && i_sreg_addr == RW'(SREG_IRQ_PEND))
                        ? (i_sreg_data[NSRC-1:0] & EDGE_MASK) : '0;
    // a fresh edge outranks any clear in the same cycle
    assign pend_edge_d = ((pend_edge_q & ~w_w1c & ~w_take_clr) | w_edge_set) & EDGE_MASK;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (w_irq)
            state_d = ST_HANDLER;
        else if (state_q == ST_HANDLER && i_irt && i_exec_submit)
            state_d = ST_RUN;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mask_q       <= '0;
            pend_edge_q  <= '0;
            irq_prev_q   <= '0;
            prev_sys_q   <= 1'b0;
            prev_trap_q  <= 1'b0;
            flush_q      <= 1'b0;
            cause_vld_q  <= 1'b0;
            cause_code_q <= '0;
            mem_pc_q     <= '0;
            irq_pc_q     <= '0;
        end else begin
            pend_edge_q <= pend_edge_d;
            irq_prev_q  <= i_irq;
            prev_sys_q  <= i_sys & i_exec_submit;
            prev_trap_q <= i_trap_flag & i_exec_submit;
            flush_q     <= w_irq;
            if (i_exec_submit) mem_pc_q <= i_exec_pc;
            if (w_irq) begin
                cause_vld_q  <= 1'b1;
                cause_code_q <= w_code;
                irq_pc_q     <= i_mem_exception ? mem_pc_q : i_exec_pc;
            end else if (w_sreg_wr && i_sreg_addr == RW'(SREG_IRQ_PC)) begin
                irq_pc_q <= i_sreg_data;
            end
            if (w_sreg_wr && i_sreg_addr == RW'(SREG_IRQ_MASK))
                mask_q <= i_sreg_data[NSRC-1:0];
        end
    end

    always_comb begin
        w_cause_rd          = '0;
        w_cause_rd[CW-1:0]  = cause_code_q;
        w_cause_rd[RW-1]    = cause_vld_q;
        case (i_sreg_addr)
            RW'(SREG_IRQ_PC):    o_sreg_data = irq_pc_q;
            RW'(SREG_IRQ_CAUSE): o_sreg_data = w_cause_rd;
            RW'(SREG_IRQ_MASK):  o_sreg_data = RW'(mask_q);
            RW'(SREG_IRQ_PEND):  o_sreg_data = RW'(w_pend);
            default:             o_sreg_data = '0;
        endcase
    end

`ifdef IRQ_VECTORED_EN
    assign o_target_pc = RW'(INT_VEC) + RW'(w_code) * RW'(VEC_STRIDE);
`else
    assign o_target_pc = RW'(INT_VEC);
`endif

    assign o_irq        = w_irq;
    assign o_flush      = flush_q;
    assign o_irq_pc     = irq_pc_q;
    assign o_in_handler = (state_q == ST_HANDLER);

endmodule

`default_nettype wire

// File: tb/tb_irq_unit.sv
//------------------------------------------------------------------------------
// tb_irq_unit : directed self-checking bench for irq_unit (NSRC=8, line 3 edge)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_unit;

    localparam int RW = 16;
    localparam int NSRC = 8;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_exec_submit = 1'b0;
    logic [RW-1:0]   i_exec_pc = '0;
    logic            i_sys = 1'b0;
    logic            i_trap_flag = 1'b0;
    logic            i_mem_exception = 1'b0;
    logic            i_irt = 1'b0;
    logic            i_irq_en = 1'b0;
    logic [NSRC-1:0] i_irq = '0;
    logic [RW-1:0]   i_sreg_addr = '0;
    logic            i_sreg_we = 1'b0;
    logic [RW-1:0]   i_sreg_data = '0;
    logic [RW-1:0]   o_sreg_data;
    logic            o_irq;
    logic            o_flush;
    logic [RW-1:0]   o_target_pc;
    logic [RW-1:0]   o_irq_pc;
    logic            o_in_handler;

    int n_vec = 0;
    int n_err = 0;

    irq_unit #(
        .RW         (RW),
        .NSRC       (NSRC),
        .EDGE_MASK  (8'h08),
        .INT_VEC    (1),
        .VEC_STRIDE (4)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_exec_submit   (i_exec_submit),
        .i_exec_pc       (i_exec_pc),
        .i_sys           (i_sys),
        .i_trap_flag     (i_trap_flag),
        .i_mem_exception (i_mem_exception),
        .i_irt           (i_irt),
        .i_irq_en        (i_irq_en),
        .i_irq           (i_irq),
        .i_sreg_addr     (i_sreg_addr),
        .i_sreg_we       (i_sreg_we),
        .i_sreg_data     (i_sreg_data),
        .o_sreg_data     (o_sreg_data),
        .o_irq           (o_irq),
        .o_flush         (o_flush),
        .o_target_pc     (o_target_pc),
        .o_irq_pc        (o_irq_pc),
        .o_in_handler    (o_in_handler)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sreg_rd(input string tag, input logic [RW-1:0] addr, input logic [RW-1:0] exp);
        i_sreg_addr = addr;
        #1;
        check(tag, 32'(o_sreg_data), 32'(exp));
    endtask

    task automatic sreg_wr(input logic [RW-1:0] addr, input logic [RW-1:0] data);
        i_sreg_addr   = addr;
        i_sreg_data   = data;
        i_sreg_we     = 1'b1;
        i_exec_submit = 1'b1;
        step();
        i_sreg_we     = 1'b0;
        i_exec_submit = 1'b0;
    endtask

    task automatic irt_commit();
        i_irt         = 1'b1;
        i_exec_submit = 1'b1;
        step();
        i_irt         = 1'b0;
        i_exec_submit = 1'b0;
    endtask

    // vectored target = 1 + code*4, flat target = 1
    function automatic logic [31:0] tgt(input int code);
`ifdef IRQ_VECTORED_EN
        return 32'(1 + code * 4);
`else
        return 32'(code - code + 1);
`endif
    endfunction

    initial begin
        step();
        step();
        i_rst = 1'b0;
        #1;
        check("rst_flush", 32'(o_flush), 0);
        check("rst_irq_pc", 32'(o_irq_pc), 0);
        check("rst_in_handler", 32'(o_in_handler), 0);
        check("rst_o_irq", 32'(o_irq), 0);
        sreg_rd("rst_cause", 16'h5, 16'h0);
        sreg_rd("rst_mask", 16'hC, 16'h0);
        sreg_rd("rst_pend", 16'hD, 16'h0);

        // level line 2 taken with zero latency
        i_irq_en = 1'b1;
        sreg_wr(16'hC, 16'h0004);
        sreg_rd("mask_rd", 16'hC, 16'h0004);
        i_exec_pc = 16'h0040;
        i_irq     = 8'h04;
        #1;
        check("l2_o_irq", 32'(o_irq), 1);
        check("l2_target", 32'(o_target_pc), tgt(2));
        step();
        sreg_rd("l2_cause", 16'h5, 16'h8002);
        check("l2_irq_pc", 32'(o_irq_pc), 32'h40);
        check("l2_flush", 32'(o_flush), 1);
        check("l2_in_handler", 32'(o_in_handler), 1);
        check("l2_blocked", 32'(o_irq), 0);
        i_irq = 8'h00;
        step();
        check("l2_flush_drop", 32'(o_flush), 0);
        irt_commit();
        check("irt_exit", 32'(o_in_handler), 0);

        // lines 1 and 5 together: lowest index first
        sreg_wr(16'hC, 16'h00FF);
        i_irq = 8'h22;
        #1;
        check("l15_o_irq", 32'(o_irq), 1);
        check("l15_target", 32'(o_target_pc), tgt(1));
        step();
        sreg_rd("l15_cause", 16'h5, 16'h8001);
        i_irq = 8'h20;
        irt_commit();
        #1;
        check("l5_o_irq", 32'(o_irq), 1);
        check("l5_target", 32'(o_target_pc), tgt(5));
        step();
        sreg_rd("l5_cause", 16'h5, 16'h8005);
        i_irq = 8'h00;
        irt_commit();
        check("l5_exit", 32'(o_in_handler), 0);

        // sys at 0x10 taken one cycle later against the next PC
        i_exec_pc     = 16'h0010;
        i_sys         = 1'b1;
        i_exec_submit = 1'b1;
        #1;
        check("sys_no_irq_yet", 32'(o_irq), 0);
        step();
        i_sys         = 1'b0;
        i_exec_submit = 1'b0;
        i_exec_pc     = 16'h0011;
        #1;
        check("sys_o_irq", 32'(o_irq), 1);
        check("sys_target", 32'(o_target_pc), tgt(8));
        step();
        sreg_rd("sys_cause", 16'h5, 16'h8008);
        check("sys_irq_pc", 32'(o_irq_pc), 32'h11);
        check("sys_flush", 32'(o_flush), 1);

        // memory exception in HANDLER uses mem_pc; line 0 is ignored
        i_exec_pc     = 16'h0022;
        i_exec_submit = 1'b1;
        step();
        i_exec_submit   = 1'b0;
        i_exec_pc       = 16'h0030;
        i_mem_exception = 1'b1;
        i_irq           = 8'h01;
        #1;
        check("mem_o_irq", 32'(o_irq), 1);
        check("mem_target", 32'(o_target_pc), tgt(10));
        step();
        i_mem_exception = 1'b0;
        sreg_rd("mem_cause", 16'h5, 16'h800A);
        check("mem_irq_pc", 32'(o_irq_pc), 32'h22);
        check("mem_in_handler", 32'(o_in_handler), 1);
        check("l0_ignored", 32'(o_irq), 0);
        i_irq = 8'h00;

        // trap beats an irt and an sreg write in the same cycle
        i_trap_flag   = 1'b1;
        i_exec_submit = 1'b1;
        step();
        i_trap_flag = 1'b0;
        i_exec_pc   = 16'h0055;
        i_irt       = 1'b1;
        i_sreg_we   = 1'b1;
        i_sreg_addr = 16'h3;
        i_sreg_data = 16'h0777;
        #1;
        check("trap_o_irq", 32'(o_irq), 1);
        step();
        i_irt         = 1'b0;
        i_sreg_we     = 1'b0;
        i_exec_submit = 1'b0;
        check("trap_stay_handler", 32'(o_in_handler), 1);
        check("trap_irq_pc", 32'(o_irq_pc), 32'h55);
        sreg_rd("trap_cause", 16'h5, 16'h8009);

        sreg_wr(16'h3, 16'h1234);
        check("irq_pc_wr", 32'(o_irq_pc), 32'h1234);
        irt_commit();
        check("trap_exit", 32'(o_in_handler), 0);

        // edge line 3, masked off
        sreg_wr(16'hC, 16'h0000);
        i_irq = 8'h08;
        step();
        sreg_rd("edge_pend", 16'hD, 16'h0008);
        check("edge_masked", 32'(o_irq), 0);
        i_irq = 8'h00;
        step();
        sreg_rd("edge_latched", 16'hD, 16'h0008);
        sreg_wr(16'hD, 16'h0008);
        sreg_rd("edge_w1c", 16'hD, 16'h0000);
        i_irq = 8'h08;
        sreg_wr(16'hD, 16'h0008);
        sreg_rd("edge_beats_w1c", 16'hD, 16'h0008);

        // unmask: edge taken and its pending bit cleared
        sreg_wr(16'hC, 16'h0008);
        #1;
        check("edge_o_irq", 32'(o_irq), 1);
        check("edge_target", 32'(o_target_pc), tgt(3));
        step();
        sreg_rd("edge_cause", 16'h5, 16'h8003);
        sreg_rd("edge_pend_clr", 16'hD, 16'h0000);

        // reset mid-handler
        i_irq = 8'h00;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        #1;
        check("rst2_in_handler", 32'(o_in_handler), 0);
        check("rst2_irq_pc", 32'(o_irq_pc), 0);
        check("rst2_flush", 32'(o_flush), 0);
        sreg_rd("rst2_cause", 16'h5, 16'h0);
        sreg_rd("rst2_mask", 16'hC, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_unit.md
# irq_unit

Parametrised interrupt and exception controller for the core pipeline, sitting beside the execute stage. It accepts NSRC external interrupt lines (each level- or edge-sensitive), plus the synchronous sys, trap and memory-exception events. It arbitrates them by fixed priority, saves the resume PC and cause, and drives the invalidate/flush pulse and the handler target PC. It also tracks handler occupancy until an irt instruction commits.

## Interface
Parameters:
- RW, 16, datapath/PC width.
- NSRC, 8, number of external interrupt lines (1..16).
- EDGE_MASK, NSRC'b0, bit i set makes line i edge-sensitive (rising edge latched into pending); clear makes it level-sensitive.
- INT_VEC, 1, handler base address.
- VEC_STRIDE, 4, distance between vectored entries (used only with IRQ_VECTORED_EN).

Ports (reset i_rst, synchronous, active-high; clock i_clk):
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_exec_submit  in  1  instruction in execute commits this cycle
- i_exec_pc  in  RW  PC of instruction currently in execute
- i_sys  in  1  committing instruction is sys (qualified by i_exec_submit)
- i_trap_flag  in  1  trap mode active (qualified by i_exec_submit)
- i_mem_exception  in  1  memory stage fault, this cycle
- i_irt  in  1  committing instruction is irt (qualified by i_exec_submit)
- i_irq_en  in  1  global interrupt enable from privilege control
- i_irq  in  NSRC  external interrupt lines
- i_sreg_addr  in  RW  special-register address
- i_sreg_we  in  1  special-register write (qualified by i_exec_submit)
- i_sreg_data  in  RW  special-register write data
- o_sreg_data  out  RW  read data for i_sreg_addr (combinational, 0 if unmapped)
- o_irq  out  1  take event this cycle (combinational); invalidates the current execute instruction
- o_flush  out  1  registered o_irq, one cycle later
- o_target_pc  out  RW  handler address, valid while o_irq
- o_irq_pc  out  RW  saved resume PC (irt source)
- o_in_handler  out  1  state is HANDLER

## Operation
- Pipeline registers:
  - prev_sys is set to 1 on the cycle after i_sys & i_exec_submit; otherwise 0.
  - prev_trap is set to 1 on the cycle after i_trap_flag & i_exec_submit; otherwise 0.
  - mem_pc takes i_exec_pc on every i_exec_submit.
- Pending: pend[i] follows i_irq[i] for level lines. For edge lines, pend[i] is set on a 0→1 transition of the line and cleared by a W1C write.
- Eligible external requests: ext = pend & mask & {NSRC{i_irq_en & ~in_handler}}.
- Priority, highest first: i_mem_exception, prev_trap, prev_sys, ext with the lowest index first.
- o_irq = any of the four sources.
- Cause code width CW = clog2(NSRC+3):
  - external line i → i
  - sys → NSRC
  - trap → NSRC+1
  - mem → NSRC+2
- On o_irq:
  - cause ← code.
  - irq_pc ← mem_pc for a memory exception, else i_exec_pc.
  - State → HANDLER.
  - For an edge source, pend is cleared for the taken line.
- State machine:
  - RUN→HANDLER on o_irq.
  - HANDLER→RUN on i_irt & i_exec_submit & ~o_irq.
  - Synchronous exceptions are still taken in HANDLER; they overwrite cause and irq_pc and the state stays HANDLER.
- Special registers (writes require i_sreg_we & i_exec_submit & ~o_irq):
  - 0x3 IRQ_PC: read/write.
  - 0x5 IRQ_CAUSE: read-only, {valid bit at RW-1, code}.
  - 0xC IRQ_MASK: read/write, low NSRC bits.
  - 0xD IRQ_PEND: read; write-1-clear for edge bits, level bits ignored.

## Timing
- Reset values:
  - o_flush 0, o_irq_pc 0, o_in_handler 0
  - mask 0, pend 0, cause 0
  - prev_sys 0, prev_trap 0, mem_pc 0
- o_irq and o_target_pc are combinational and have zero latency from a level source or i_mem_exception. o_flush follows one cycle later.
- sys committed in cycle N → o_irq in N+1 with irq_pc = i_exec_pc(N+1), i.e. the next instruction → o_flush in N+2. Trap behaves identically.
- Simultaneous events:
  - o_irq beats an irt and an sreg write in the same cycle; both are ignored.
  - An edge set beats a W1C clear of the same bit.
- Reset mid-handler returns the block to RUN with every register at its reset value.

## Configuration
- IRQ_VECTORED_EN defined: o_target_pc = INT_VEC + code*VEC_STRIDE (RW-bit wrap).
- IRQ_VECTORED_EN undefined: o_target_pc = INT_VEC for every source. The cause register is still maintained.

## Structure
- Shared package holds:
  - sreg address constants (IRQ_PC, IRQ_CAUSE, IRQ_MASK, IRQ_PEND)
  - state encoding RUN/HANDLER
  - cause-code offsets (SYS, TRAP, MEM relative to NSRC)
- One sub-module, irq_prio_enc: parametrised priority encoder producing {hit, code}.

## Test plan
- NSRC=8, mask=0x04, i_irq_en=1, raise i_irq[2] at i_exec_pc=0x40 → o_irq the same cycle; cause=0x8002, irq_pc=0x40, o_flush next cycle, o_in_handler=1.
- i_irq[1] and i_irq[5] together, mask=0xFF → code 1 taken. After irt commits, line 5 (still high) taken → code 5.
- sys commits at pc 0x10, next i_exec_pc 0x11 → o_irq one cycle later; code=NSRC (8), irq_pc=0x11.
- In HANDLER, raise i_mem_exception with mem_pc=0x22 → taken; code=10, irq_pc=0x22. External i_irq[0] ignored while in HANDLER.
- Edge line 3 (EDGE_MASK=0x08), mask=0 → pend[3]=1 and no o_irq. W1C 0x08 written in the same cycle as a new edge → pend stays 1.
- IRQ_VECTORED_EN, INT_VEC=1, VEC_STRIDE=4, line 2 taken → o_target_pc=9. Without the macro → o_target_pc=1.
